scaler_cfg_ctrl: RTL

Frame-synchronous configuration controller for the video scaler path. It accepts a crop window, output resolution and algorithm select from the host, then validates the request. It computes the Q4.14 scale factors with a sequential restoring divider, which replaces the wide combinational divide. New values are committed to the scaler at the next frame start, and the block issues the scaler's one-cycle `start` pulse.

---
 rtl/scaler_cfg_ctrl_if.sv | 37 +++
 rtl/scaler_cfg_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_cfg_ctrl_if.sv
// Host-side configuration bus of the scaler configuration controller.
// Carries the request strobe with its crop window, output resolution and
// algorithm select, plus the status flags that the controller reports back.
//   master : host (drives the request, reads status)
//   slave  : scaler_cfg_ctrl (reads the request, drives status)
interface scaler_cfg_ctrl_if #(
    parameter int IN_X_W  = 11,
    parameter int IN_Y_W  = 11,
    parameter int OUT_X_W = 11,
    parameter int OUT_Y_W = 11
);
    logic               cfg_wr;
    logic [IN_X_W-1:0]  cfg_start_x;
    logic [IN_X_W-1:0]  cfg_end_x;
    logic [IN_Y_W-1:0]  cfg_start_y;
    logic [IN_Y_W-1:0]  cfg_end_y;
    logic [OUT_X_W-1:0] cfg_out_x_res;
    logic [OUT_Y_W-1:0] cfg_out_y_res;
    logic               cfg_nearest;
    logic               cfg_busy;
    logic               cfg_pending;
    logic               cfg_applied;
    logic               cfg_err;
    logic               cfg_sat;

    modport master (
        output cfg_wr, cfg_start_x, cfg_end_x, cfg_start_y, cfg_end_y,
               cfg_out_x_res, cfg_out_y_res, cfg_nearest,
        input  cfg_busy, cfg_pending, cfg_applied, cfg_err, cfg_sat
    );

    modport slave (
        input  cfg_wr, cfg_start_x, cfg_end_x, cfg_start_y, cfg_end_y,
               cfg_out_x_res, cfg_out_y_res, cfg_nearest,
        output cfg_busy, cfg_pending, cfg_applied, cfg_err, cfg_sat
    );
endinterface

// File: rtl/scaler_cfg_ctrl.sv
// Frame-synchronous configuration controller for the video scaler.
// A host request (crop window, output resolution, algorithm) is validated,
// the Q4.14 scale factors are computed with a sequential restoring divider
// (one quotient bit per cycle), and the result is committed to the active
// outputs on the next vsync rising edge while in PEND.
// Ports:
//   clk, rst_n         : pixel clock, async active-low reset
//   cfg                : host request/status bus (slave side)
//   vs_i               : frame vsync level, synchronous to clk
//   input_*_res        : active input resolution minus 1
//   output_*_res       : active output resolution minus 1
//   x_scale, y_scale   : active scale factors, Q4.14
//   nearest            : active algorithm select (1 = nearest-neighbour)
//   frame_start        : one-cycle scaler start, one cycle after a commit
module scaler_cfg_ctrl #(
    parameter int IN_X_W          = 11,
    parameter int IN_Y_W          = 11,
    parameter int OUT_X_W         = 11,
    parameter int OUT_Y_W         = 11,
    parameter int SCALE_INT_BITS  = 4,
    parameter int SCALE_FRAC_BITS = 14,
    parameter int RST_IN_X        = 1919,
    parameter int RST_IN_Y        = 1079,
    parameter int RST_OUT_X       = 1919,
    parameter int RST_OUT_Y       = 1079
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    scaler_cfg_ctrl_if.slave                          cfg,
    input  logic                                      vs_i,
    output logic [IN_X_W-1:0]                         input_x_res,
    output logic [IN_Y_W-1:0]                         input_y_res,
    output logic [OUT_X_W-1:0]                        output_x_res,
    output logic [OUT_Y_W-1:0]                        output_y_res,
    output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] x_scale,
    output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] y_scale,
    output logic                                      nearest,
    output logic                                      frame_start
);
    localparam int SB    = SCALE_INT_BITS + SCALE_FRAC_BITS;
    localparam int IN_W  = (IN_X_W > IN_Y_W) ? IN_X_W : IN_Y_W;
    localparam int OUT_W = (OUT_X_W > OUT_Y_W) ? OUT_X_W : OUT_Y_W;
    localparam int NUM_W = IN_W + SCALE_FRAC_BITS;
    localparam int DEN_W = OUT_W + 1;
    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_W - 1);
    localparam logic [SB-1:0]    SCALE_ONE = SB'(1) << SCALE_FRAC_BITS;
    localparam logic [SB-1:0]    SCALE_MAX = '1;

    typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, PEND} state_t;

    typedef struct packed {
        logic [IN_X_W-1:0]  in_x;
        logic [IN_Y_W-1:0]  in_y;
        logic [OUT_X_W-1:0] out_x;
        logic [OUT_Y_W-1:0] out_y;
        logic [SB-1:0]      xs;
        logic [SB-1:0]      ys;
        logic               nearest;
    } act_cfg_t;

    typedef struct packed {
        logic [IN_X_W-1:0] sx;
        logic [IN_X_W-1:0] ex;
        logic [IN_Y_W-1:0] sy;
        logic [IN_Y_W-1:0] ey;
    } crop_t;

    localparam act_cfg_t ACT_RST = '{
        in_x: IN_X_W'(RST_IN_X), in_y: IN_Y_W'(RST_IN_Y),
        out_x: OUT_X_W'(RST_OUT_X), out_y: OUT_Y_W'(RST_OUT_Y),
        xs: SCALE_ONE, ys: SCALE_ONE, nearest: 1'b0};

    state_t           state_q, state_d;
    crop_t            crop_q, crop_d;
    act_cfg_t         sh_q, sh_d;      // shadow config being built
    act_cfg_t         act_q, act_d;    // config seen by the scaler
    logic [NUM_W-1:0] num_q, num_d;    // dividend shifting out, quotient shifting in
    logic [OUT_W-1:0] rem_q, rem_d;    // partial remainder, always < divisor
    logic [DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             sat_q, sat_d;
    logic             applied_q, applied_d;
    logic             vs_d_q, vs_d_d;
    logic             rise_q, rise_d;
    logic             frame_start_q, frame_start_d;

    logic             vs_rise;
    logic [DEN_W-1:0] rem_sh;
    logic             q_bit;
    logic [NUM_W-1:0] quo;
    logic             quo_sat;
    logic [SB-1:0]    scale;
    logic [IN_X_W-1:0] width_x;
    logic [IN_Y_W-1:0] width_y;

    assign vs_rise = vs_i & ~vs_d_q;

    always_comb begin
        state_d       = state_q;
        crop_d        = crop_q;
        sh_d          = sh_q;
        act_d         = act_q;
        num_d         = num_q;
        rem_d         = rem_q;
        den_d         = den_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        sat_d         = sat_q;
        applied_d     = 1'b0;
        vs_d_d        = vs_i;
        rise_d        = vs_rise;
        // Commit lands one cycle before the scaler's start pulse.
        frame_start_d = rise_q;

        // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
        rem_sh  = {rem_q, num_q[NUM_W-1]};
        q_bit   = (rem_sh >= den_q);
        quo     = {num_q[NUM_W-2:0], q_bit};
        quo_sat = |quo[NUM_W-1:SB];
        scale   = quo_sat ? SCALE_MAX : quo[SB-1:0];
        width_x = crop_q.ex - crop_q.sx;
        width_y = crop_q.ey - crop_q.sy;

        case (state_q)
            IDLE, PEND: begin
                // Commit uses the old shadow even when a new request arrives this cycle.
                if (state_q == PEND && vs_rise) begin
                    act_d     = sh_q;
                    applied_d = 1'b1;
                    state_d   = IDLE;
                end
                if (cfg.cfg_wr) begin
                    crop_d       = '{sx: cfg.cfg_start_x, ex: cfg.cfg_end_x,
                                     sy: cfg.cfg_start_y, ey: cfg.cfg_end_y};
                    sh_d.out_x   = cfg.cfg_out_x_res;
                    sh_d.out_y   = cfg.cfg_out_y_res;
                    sh_d.nearest = cfg.cfg_nearest;
                    err_d        = 1'b0;
                    sat_d        = 1'b0;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (crop_q.ex <= crop_q.sx || crop_q.ey <= crop_q.sy) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    sh_d.in_x = width_x - 1'b1;
                    sh_d.in_y = width_y - 1'b1;
                    num_d     = NUM_W'(width_x) << SCALE_FRAC_BITS;
                    den_d     = DEN_W'(sh_q.out_x) + 1'b1;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = DIV_X;
                end
            end
            DIV_X, DIV_Y: begin
                num_d = quo;
                rem_d = OUT_W'(q_bit ? rem_sh - den_q : rem_sh);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sat_d = sat_q | quo_sat;
                    if (state_q == DIV_X) begin
                        sh_d.xs = scale;
                        num_d   = (NUM_W'(sh_q.in_y) + NUM_W'(1)) << SCALE_FRAC_BITS;
                        den_d   = DEN_W'(sh_q.out_y) + 1'b1;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = DIV_Y;
                    end else begin
                        sh_d.ys = scale;
                        state_d = PEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            crop_q        <= '0;
            sh_q          <= '0;
            act_q         <= ACT_RST;
            num_q         <= '0;
            rem_q         <= '0;
            den_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            sat_q         <= 1'b0;
            applied_q     <= 1'b0;
            vs_d_q        <= 1'b0;
            rise_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            crop_q        <= crop_d;
            sh_q          <= sh_d;
            act_q         <= act_d;
            num_q         <= num_d;
            rem_q         <= rem_d;
            den_q         <= den_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            sat_q         <= sat_d;
            applied_q     <= applied_d;
            vs_d_q        <= vs_d_d;
            rise_q        <= rise_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign input_x_res     = act_q.in_x;
    assign input_y_res     = act_q.in_y;
    assign output_x_res    = act_q.out_x;
    assign output_y_res    = act_q.out_y;
    assign x_scale         = act_q.xs;
    assign y_scale         = act_q.ys;
    assign nearest         = act_q.nearest;
    assign frame_start     = frame_start_q;
    assign cfg.cfg_busy    = (state_q == CHECK) || (state_q == DIV_X) || (state_q == DIV_Y);
    assign cfg.cfg_pending = (state_q == PEND);
    assign cfg.cfg_applied = applied_q;
    assign cfg.cfg_err     = err_q;
    assign cfg.cfg_sat     = sat_q;
endmodule
